scfifo_rd_stream: RTL and testbench



---
 rtl/scfifo_rd_stream_pkg.sv | 20 ++
 rtl/scfifo_rd_stream_if.sv | 29 ++
 rtl/scfifo_rd_stream_buf2.sv | 67 ++++++
 rtl/scfifo_rd_stream.sv | 76 +++++++
 tb/tb_scfifo_rd_stream.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scfifo_rd_stream_pkg.sv
// Shared types for the scfifo_rd_stream read adapter.
// Optional transfer counter: define SCFIFO_RD_STREAM_CNT_EN.
package scfifo_rd_stream_pkg;

  // Number of words the adapter can hold (buffered plus in flight).
  localparam int BUF_DEPTH = 2;

  // Buffer occupancy; encodings equal the number of words held.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // Occupancy as an unsigned word count.
  function automatic logic [1:0] occ_count(input occ_t occ);
    return 2'(occ);
  endfunction

endpackage

// File: rtl/scfifo_rd_stream_if.sv
// FIFO-side and stream-side signals of the scfifo_rd_stream adapter.
// Optional transfer counter: define SCFIFO_RD_STREAM_CNT_EN.
//
// Handshake: a word moves on every rising clock edge where o_valid and
// o_ready are both high. Once o_valid is high, o_valid and o_data stay
// constant until that transfer; o_ready may change in any cycle and has
// no effect while o_valid is low.
interface scfifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_empty;
  logic             fifo_rdreq;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_ready;

  // Adapter view.
  modport master (
    input  fifo_q, fifo_empty, o_ready,
    output fifo_rdreq, o_data, o_valid
  );

  // FIFO and stream-sink view.
  modport slave (
    output fifo_q, fifo_empty, o_ready,
    input  fifo_rdreq, o_data, o_valid
  );
endinterface

// File: rtl/scfifo_rd_stream_buf2.sv
// Two-entry head/tail skid buffer for scfifo_rd_stream.
// Head drives the stream outputs; tail holds the second word.
// Optional transfer counter: define SCFIFO_RD_STREAM_CNT_EN (not used here).
module rd_stream_buf2
  import scfifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output occ_t             occ
);

  logic [WIDTH-1:0] tail_data;

  // Occupancy FSM; places each arriving word in the next free slot after pop.
  always_ff @(posedge clock) begin
    if (sclr) begin
      head_data  <= '0;
      tail_data  <= '0;
      head_valid <= 1'b0;
      occ        <= OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (wr) begin
            head_data  <= wr_data;
            head_valid <= 1'b1;
            occ        <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (wr && pop) begin
            head_data <= wr_data;
          end else if (wr) begin
            tail_data <= wr_data;
            occ       <= OCC_TWO;
          end else if (pop) begin
            head_valid <= 1'b0;
            occ        <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // An arrival without a pop cannot happen here: rdreq is withheld.
          if (pop) begin
            head_data <= tail_data;
            if (wr) begin
              tail_data <= wr_data;
            end else begin
              occ <= OCC_ONE;
            end
          end
        end
        default: begin
          head_valid <= 1'b0;
          occ        <= OCC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/scfifo_rd_stream.sv
// Read-side adapter for a normal-mode single-clock FIFO: issues rdreq,
// absorbs the one-cycle read latency and presents a registered
// valid/ready stream at full throughput.
// Optional transfer counter: define SCFIFO_RD_STREAM_CNT_EN.
module scfifo_rd_stream
  import scfifo_rd_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 sclr,
`ifdef SCFIFO_RD_STREAM_CNT_EN
  output logic [CNT_WIDTH-1:0] xfer_cnt,
`endif
  scfifo_rd_stream_if.master   bus
);

  logic             inflight;
  logic             pop;
  logic             rdreq;
  logic [1:0]       occ_sum;
  occ_t             occ;
  logic [WIDTH-1:0] head_data;
  logic             head_valid;

  assign pop = head_valid & bus.o_ready;

  // Words held after this cycle if no read were issued; never exceeds 3.
  assign occ_sum = occ_count(occ) + {1'b0, inflight} - {1'b0, pop};

  // Read only when the word returning next cycle is sure to find a slot.
  assign rdreq = ~sclr & ~bus.fifo_empty & (occ_sum < 2'(BUF_DEPTH));

  assign bus.fifo_rdreq = rdreq;
  assign bus.o_data     = head_data;
  assign bus.o_valid    = head_valid;

  // inflight marks that fifo_q carries a freshly read word this cycle.
  always_ff @(posedge clock) begin
    if (sclr) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rdreq;
    end
  end

  rd_stream_buf2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clock      (clock),
    .sclr       (sclr),
    .wr         (inflight),
    .wr_data    (bus.fifo_q),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .occ        (occ)
  );

`ifdef SCFIFO_RD_STREAM_CNT_EN
  // Count accepted words, wrapping at 2^CNT_WIDTH.
  always_ff @(posedge clock) begin
    if (sclr) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end
`else
  // Keeps CNT_WIDTH referenced when the counter is not built.
  logic [CNT_WIDTH-1:0] cnt_unused;
  assign cnt_unused = '0;
`endif

endmodule

// File: tb/tb_scfifo_rd_stream.sv
// Testbench for scfifo_rd_stream: behavioural normal-mode FIFO model,
// cycle table for reset/latency/stall, directed sequences for streaming,
// random backpressure, drain and mid-stream reset.
// Optional transfer counter: define SCFIFO_RD_STREAM_CNT_EN.
module tb_scfifo_rd_stream;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic sclr;
  always #5 clock = ~clock;

  scfifo_rd_stream_if #(.WIDTH(W)) bus();

`ifdef SCFIFO_RD_STREAM_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  scfifo_rd_stream #(
    .WIDTH     (W),
    .CNT_WIDTH (16)
  ) dut (
    .clock    (clock),
    .sclr     (sclr),
`ifdef SCFIFO_RD_STREAM_CNT_EN
    .xfer_cnt (xfer_cnt),
`endif
    .bus      (bus)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mem[$];     // FIFO contents
  logic [W-1:0] exp_q[$];   // scoreboard: words expected on the stream
  int cycle = 0;
  int underflow = 0;
  int reads = 0;
  int pops = 0;
  int max_out = 0;
  int first_rd = -1;
  int first_valid = -1;
  int first_pop = -1;
  int last_pop = -1;
  bit mon_en = 1'b0;

  // Normal-mode FIFO: q updates on the edge after rdreq, empty is registered.
  always @(posedge clock) begin
    cycle = cycle + 1;
    if (sclr) bus.fifo_q <= '0;
    if (bus.fifo_rdreq === 1'b1) begin
      if (mem.size() == 0) underflow = underflow + 1;
      else bus.fifo_q <= mem.pop_front();
    end
    bus.fifo_empty <= (mem.size() == 0);
  end

  // Stream monitor, sampled mid-cycle after inputs have settled.
  always @(negedge clock) begin
    #2;
    if (mon_en && !sclr) begin
      if (reads - pops > max_out) max_out = reads - pops;
      if (bus.fifo_rdreq === 1'b1) begin
        reads = reads + 1;
        if (first_rd < 0) first_rd = cycle;
      end
      if (bus.o_valid === 1'b1 && first_valid < 0) first_valid = cycle;
      if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
        pops = pops + 1;
        if (first_pop < 0) first_pop = cycle;
        last_pop = cycle;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL pop_order: got %0h, required no word (nothing pending)", bus.o_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (bus.o_data !== e) begin
            errors = errors + 1;
            $display("FAIL pop_order: got %0h, required %0h", bus.o_data, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    mem.push_back(w);
    exp_q.push_back(w);
  endtask

  // FIFO and adapter share sclr, so the FIFO is flushed along with it.
  task automatic do_reset(input int n);
    @(negedge clock);
    sclr = 1'b1;
    mem.delete();
    exp_q.delete();
    repeat (n) @(negedge clock);
    sclr = 1'b0;
    reads = 0; pops = 0; max_out = 0;
    first_rd = -1; first_valid = -1; first_pop = -1; last_pop = -1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (pops < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(name, pops, n);
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic         sclr;
    logic         wr;
    logic [W-1:0] data;
    logic         ready;
    logic         e_rd;
    logic         e_val;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sclr = 1'b1;
    bus.o_ready = 1'b0;

    //           sclr  wr    data   ready e_rd  e_val e_data
    vecs[0]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h05};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

    @(posedge clock);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      sclr = vecs[i].sclr;
      bus.o_ready = vecs[i].ready;
      if (vecs[i].wr) mem.push_back(vecs[i].data);
      #1;
      check($sformatf("tbl%0d_rdreq", i), 32'(bus.fifo_rdreq), 32'(vecs[i].e_rd));
      check($sformatf("tbl%0d_valid", i), 32'(bus.o_valid), 32'(vecs[i].e_val));
      check($sformatf("tbl%0d_data", i), 32'(bus.o_data), 32'(vecs[i].e_data));
    end

    mon_en = 1'b1;

    // Streaming: 16 words, sink always ready.
    do_reset(1);
    bus.o_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    wait_pops(16, 100, "stream_pops");
    check("stream_latency", 32'(first_valid - first_rd), 32'd2);
    check("stream_b2b", 32'(last_pop - first_pop), 32'd15);
    check("stream_maxout", 32'(max_out), 32'd2);

    // Stall: sink not ready, then released.
    do_reset(1);
    bus.o_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (10) @(negedge clock);
    #1;
    check("stall_reads", 32'(reads), 32'd2);
    check("stall_valid", 32'(bus.o_valid), 32'd1);
    check("stall_data", 32'(bus.o_data), 32'h01);
    check("stall_usedw", 32'(mem.size()), 32'd6);
    bus.o_ready = 1'b1;
    wait_pops(8, 50, "stall_pops");
    check("stall_b2b", 32'(last_pop - first_pop), 32'd7);

    // Random backpressure with trickled writes.
    do_reset(1);
    begin
      int sent;
      int k;
      sent = 0;
      k = 0;
      while ((pops < 1000) && k < 20000) begin
        @(negedge clock);
        bus.o_ready = 1'($urandom_range(0, 1));
        if (sent < 1000 && $urandom_range(0, 1) == 1) begin
          push(8'($urandom_range(0, 255)));
          sent++;
        end
        k++;
      end
    end
    check("rand_pops", 32'(pops), 32'd1000);
    check("rand_underflow", 32'(underflow), 32'd0);
    check("rand_leftover", 32'(exp_q.size()), 32'd0);
    check("rand_maxout", 32'(max_out <= 2), 32'd1);

    // Drain: one word only.
    do_reset(1);
    bus.o_ready = 1'b1;
    push(8'hA5);
    repeat (8) @(negedge clock);
    #1;
    check("drain_reads", 32'(reads), 32'd1);
    check("drain_pops", 32'(pops), 32'd1);
    check("drain_valid", 32'(bus.o_valid), 32'd0);
    check("drain_data", 32'(bus.o_data), 32'hA5);

    // Reset with two words outstanding (one buffered, one in flight).
    do_reset(1);
    bus.o_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (3) @(negedge clock);
    #1;
    check("mid_valid_pre", 32'(bus.o_valid), 32'd1);
    check("mid_data_pre", 32'(bus.o_data), 32'h11);
    check("mid_outstanding", 32'(reads - pops), 32'd2);
    sclr = 1'b1;
    mem.delete();
    exp_q.delete();
    #1;
    check("mid_rdreq_sclr", 32'(bus.fifo_rdreq), 32'd0);
    @(negedge clock);
    sclr = 1'b0;
    reads = 0; pops = 0;
    #1;
    check("mid_valid_post", 32'(bus.o_valid), 32'd0);
    check("mid_data_post", 32'(bus.o_data), 32'h00);
`ifdef SCFIFO_RD_STREAM_CNT_EN
    check("cnt_after_sclr", 32'(xfer_cnt), 32'd0);
`endif
    bus.o_ready = 1'b1;
    push(8'h55);
    wait_pops(1, 20, "mid_recover_pops");
    repeat (3) @(negedge clock);
    check("mid_recover_extra", 32'(pops), 32'd1);

`ifdef SCFIFO_RD_STREAM_CNT_EN
    // Counter wrap: 0xFFFF + 2 pops leaves a count of 1.
    check("cnt_one", 32'(xfer_cnt), 32'd1);
    do_reset(1);
    #1;
    check("cnt_reset", 32'(xfer_cnt), 32'd0);
    bus.o_ready = 1'b1;
    for (int i = 0; i < 65537; i++) push(8'(i));
    wait_pops(65537, 66000, "cnt_pops");
    #1;
    check("cnt_wrap", 32'(xfer_cnt), 32'd1);
`endif

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
